// File: rtl/palette_fader_if.sv
// Pixel lookup, palette write and fade-control bundle for palette_fader.
// Master drives index/write/fade requests; slave returns scaled colour and fade status.
interface palette_fader_if #(
    parameter int INDEX_W = 4,
    parameter int COLOR_W = 4
);
    logic [INDEX_W-1:0]   pix_index;
    logic [COLOR_W-1:0]   red;
    logic [COLOR_W-1:0]   green;
    logic [COLOR_W-1:0]   blue;
    logic                 transparent;
    logic                 wr_en;
    logic [INDEX_W-1:0]   wr_addr;
    logic [3*COLOR_W-1:0] wr_data;
    logic                 frame_tick;
    logic                 fade_start;
    logic                 fade_dir;
    logic                 fade_busy;
    logic                 fade_done;
    logic [COLOR_W:0]     level;

    modport master (
        output pix_index, wr_en, wr_addr, wr_data, frame_tick, fade_start, fade_dir,
        input  red, green, blue, transparent, fade_busy, fade_done, level
    );

    modport slave (
        input  pix_index, wr_en, wr_addr, wr_data, frame_tick, fade_start, fade_dir,
        output red, green, blue, transparent, fade_busy, fade_done, level
    );
endinterface

// File: rtl/palette_fader.sv
// Runtime-writable colour palette with registered, brightness-scaled lookup and a
// frame-synchronous fade engine. Optional colour-key output: PALETTE_TRANSPARENCY_EN.
module palette_fader #(
    parameter int INDEX_W         = 4,
    parameter int COLOR_W         = 4,
    parameter int FADE_DIV        = 2,
    parameter int TRANSPARENT_IDX = 0
) (
    input logic            clk,
    input logic            rst,
    palette_fader_if.slave bus
);
    localparam int               ENTRIES = 1 << INDEX_W;
    localparam int               DIV_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [COLOR_W:0] FULL    = {1'b1, {COLOR_W{1'b0}}};
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FADE_DIV - 1);

`ifdef PALETTE_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    typedef enum logic {IDLE, FADING} state_t;

    state_t               state_q, state_d;
    logic [COLOR_W:0]     level_q, level_d;
    logic [COLOR_W:0]     target_q, target_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 done_q, done_d;

    logic [3*COLOR_W-1:0] entries [ENTRIES];
    logic [3*COLOR_W-1:0] rd_entry;
    logic                 key_hit;
    logic [COLOR_W-1:0]   red_q, green_q, blue_q;
    logic                 transp_q;

    // Widen before multiplying so the full product survives, then keep the upper half.
    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [COLOR_W:0]   lvl);
        logic [2*COLOR_W:0] prod;
        prod = {{(COLOR_W+1){1'b0}}, c} * {{COLOR_W{1'b0}}, lvl};
        return COLOR_W'(prod >> COLOR_W);
    endfunction

    // NOTE: entries must clear on reset, so the palette is built from resettable
    // flops rather than a RAM macro, which cannot be cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
        end else if (bus.wr_en) begin
            entries[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read is combinational off the pre-edge array, giving read-before-write.
    assign rd_entry = entries[bus.pix_index];
    assign key_hit  = TRANSP_EN && (bus.pix_index == INDEX_W'(TRANSPARENT_IDX));

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            transp_q <= 1'b0;
        end else begin
            red_q    <= key_hit ? '0 : scale(rd_entry[3*COLOR_W-1:2*COLOR_W], level_q);
            green_q  <= key_hit ? '0 : scale(rd_entry[2*COLOR_W-1:COLOR_W], level_q);
            blue_q   <= key_hit ? '0 : scale(rd_entry[COLOR_W-1:0], level_q);
            transp_q <= key_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            level_q  <= FULL;
            target_q <= FULL;
            div_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            div_q    <= div_d;
            done_q   <= done_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        logic [COLOR_W:0] tgt;
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        div_d    = div_q;
        done_d   = 1'b0;
        tgt      = bus.fade_dir ? FULL : '0;

        unique case (state_q)
            IDLE: begin
                // frame_tick is not counted here, so a coincident start always wins.
                if (bus.fade_start) begin
                    div_d    = '0;
                    target_d = tgt;
                    if (level_q == tgt) done_d  = 1'b1;
                    else                state_d = FADING;
                end
            end
            FADING: begin
                if (bus.frame_tick) begin
                    if (div_q == DIV_MAX) begin
                        div_d   = '0;
                        level_d = (target_q > level_q) ? level_q + 1'b1 : level_q - 1'b1;
                        if (level_d == target_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.transparent = transp_q;
    assign bus.level       = level_q;
    assign bus.fade_busy   = (state_q == FADING);
    assign bus.fade_done   = done_q;
endmodule

// File: tb/tb_palette_fader.sv
// Directed self-checking bench for palette_fader (INDEX_W=4, COLOR_W=4, FADE_DIV=2).
// Expected values are hand-computed; transparency expectations follow PALETTE_TRANSPARENCY_EN.
module tb_palette_fader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   base     = 0;

    palette_fader_if #(.INDEX_W(4), .COLOR_W(4)) bus ();

    palette_fader #(
        .INDEX_W(4), .COLOR_W(4), .FADE_DIV(2), .TRANSPARENT_IDX(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Each cycle fade_done is high counts once, so a stretched pulse shows up as >1.
    always @(negedge clk) if (bus.fade_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        step();
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [11:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic check_rgb(input string tag, input logic [11:0] exp);
        check({tag, "_rgb"}, {20'd0, bus.red, bus.green, bus.blue}, {20'd0, exp});
    endtask

    initial begin
        bus.pix_index  = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.frame_tick = 1'b0;
        bus.fade_start = 1'b0;
        bus.fade_dir   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 32'(bus.level), 32'd16);
        check_rgb("rst", 12'h000);
        check("rst_busy", 32'(bus.fade_busy), 32'd0);
        check("rst_done", 32'(bus.fade_done), 32'd0);
        check("rst_transp", 32'(bus.transparent), 32'd0);
        rst = 1'b0;

        // Write entry 3 while looking it up: old value now, new value next cycle.
        bus.pix_index = 4'd3;
        write_entry(4'd3, 12'hEC6);
        check_rgb("rbw3_old", 12'h000);
        step();
        check_rgb("lookup3", 12'hEC6);
        check("lookup3_level", 32'(bus.level), 32'd16);

        bus.pix_index = 4'd5;
        write_entry(4'd5, 12'hAAA);
        check_rgb("rbw5_old", 12'h000);
        step();
        check_rgb("rbw5_new", 12'hAAA);

        // Fade out from full with entry 1 = F/8/2.
        bus.pix_index = 4'd1;
        write_entry(4'd1, 12'hF82);
        step();
        check_rgb("full_f82", 12'hF82);
        base = done_cnt;
        bus.fade_start = 1'b1;
        bus.fade_dir   = 1'b0;
        step();
        bus.fade_start = 1'b0;
        check("out_busy_rise", 32'(bus.fade_busy), 32'd1);
        pulse_tick();
        check("out_lvl_1tick", 32'(bus.level), 32'd16);
        pulse_tick();
        check("out_lvl_2ticks", 32'(bus.level), 32'd15);
        check_rgb("out_l15", 12'hE71);
        repeat (30) pulse_tick();
        check("out_lvl_end", 32'(bus.level), 32'd0);
        check_rgb("out_l0", 12'h000);
        check("out_busy_end", 32'(bus.fade_busy), 32'd0);
        check("out_done_cnt", 32'(done_cnt - base), 32'd1);

        // Fade in; an opposite request mid-fade must be ignored.
        base = done_cnt;
        bus.fade_start = 1'b1;
        bus.fade_dir   = 1'b1;
        step();
        bus.fade_start = 1'b0;
        check("in_busy_rise", 32'(bus.fade_busy), 32'd1);
        repeat (5) pulse_tick();
        check("in_lvl_5ticks", 32'(bus.level), 32'd2);
        bus.fade_start = 1'b1;
        bus.fade_dir   = 1'b0;
        step();
        bus.fade_start = 1'b0;
        bus.fade_dir   = 1'b1;
        check("in_ignore_busy", 32'(bus.fade_busy), 32'd1);
        check("in_ignore_lvl", 32'(bus.level), 32'd2);
        repeat (26) pulse_tick();
        check("in_lvl_31ticks", 32'(bus.level), 32'd15);
        check("in_busy_31ticks", 32'(bus.fade_busy), 32'd1);
        pulse_tick();
        check("in_lvl_end", 32'(bus.level), 32'd16);
        check("in_busy_end", 32'(bus.fade_busy), 32'd0);
        check("in_done_cnt", 32'(done_cnt - base), 32'd1);
        check_rgb("in_l16", 12'hF82);

        // Fade in requested while already at full: immediate done, never busy.
        base = done_cnt;
        bus.fade_start = 1'b1;
        bus.fade_dir   = 1'b1;
        step();
        bus.fade_start = 1'b0;
        check("noop_done", 32'(bus.fade_done), 32'd1);
        check("noop_busy", 32'(bus.fade_busy), 32'd0);
        step();
        check("noop_done_fall", 32'(bus.fade_done), 32'd0);
        check("noop_busy2", 32'(bus.fade_busy), 32'd0);
        check("noop_done_cnt", 32'(done_cnt - base), 32'd1);

        // Coincident start and tick in IDLE: the tick is not counted.
        bus.fade_start = 1'b1;
        bus.fade_dir   = 1'b0;
        bus.frame_tick = 1'b1;
        step();
        bus.fade_start = 1'b0;
        bus.frame_tick = 1'b0;
        check("coinc_busy", 32'(bus.fade_busy), 32'd1);
        pulse_tick();
        check("coinc_lvl_1tick", 32'(bus.level), 32'd16);
        pulse_tick();
        check("coinc_lvl_2ticks", 32'(bus.level), 32'd15);
        repeat (16) pulse_tick();
        check("mid_lvl7", 32'(bus.level), 32'd7);
        check_rgb("mid_l7", 12'h630);

        // Asynchronous reset mid-fade, between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check("arst_level", 32'(bus.level), 32'd16);
        check("arst_busy", 32'(bus.fade_busy), 32'd0);
        check("arst_done", 32'(bus.fade_done), 32'd0);
        check_rgb("arst", 12'h000);
        step();
        rst = 1'b0;
        step();
        check_rgb("arst_entry1", 12'h000);
        bus.pix_index = 4'd3;
        step();
        check_rgb("arst_entry3", 12'h000);

        // Transparent index handling.
        bus.pix_index = 4'd0;
        write_entry(4'd0, 12'hFFF);
        step();
`ifdef PALETTE_TRANSPARENCY_EN
        check("key_transp", 32'(bus.transparent), 32'd1);
        check_rgb("key", 12'h000);
`else
        check("key_transp", 32'(bus.transparent), 32'd0);
        check_rgb("key", 12'hFFF);
`endif
        bus.pix_index = 4'd3;
        write_entry(4'd3, 12'h123);
        step();
        check("nonkey_transp", 32'(bus.transparent), 32'd0);
        check_rgb("nonkey", 12'h123);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
